// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core front end.
//   XLEN      : default architectural register / PC width
//   RV_NOP    : canonical NOP encoding (addi x0, x0, 0)
//   RESET_PC  : default fetch address after reset
//   if_entry_t: one fetch-buffer entry {pc, instr[, fault]}
// Optional feature macro: IF_MISALIGN_EXC_EN adds the per-entry fault bit.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int              XLEN     = 32;
  localparam logic [31:0]     RV_NOP   = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
`ifdef IF_MISALIGN_EXC_EN
    logic            fault;
`endif
  } if_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_fifo
// Small synchronous FIFO holding fetched {pc, instr[, fault]} words.
// The head entry is read combinationally, so a pushed word is visible the
// cycle after the push with no extra read latency.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous reset, active-high
//   flush_i    : drop all entries at the clock edge (wins over push/pop)
//   push_i     : write push_data_i at the tail
//   push_data_i: entry to write
//   pop_i      : retire the head entry
//   head_o     : current head entry (meaningful when !empty_o)
//   count_o    : number of valid entries
//   empty_o    : no valid entries
// -----------------------------------------------------------------------------
module if_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only observed once
  // count_q says it was written, so clearing it would cost flops for nothing.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end: generates sequential PCs, reads a synchronous
// instruction memory (1-cycle latency), buffers {pc, instr} pairs and hands
// them to decode over valid/ready. A redirect flushes buffered and in-flight
// fetches and restarts fetch at redirect_pc.
// Ports:
//   clk            : clock
//   rst_n          : synchronous reset, ACTIVE-HIGH despite the name
//   redirect_valid : redirect fetch this cycle
//   redirect_pc    : new fetch PC
//   imem_req       : instruction-memory read enable
//   imem_addr      : word address (byte PC bits [IMEM_AW+1:2])
//   imem_rdata     : read data, valid the cycle after imem_req
//   id_valid       : head entry valid to decode
//   id_ready       : decode accepts the head entry
//   id_pc/id_instr : head entry
//   id_fault       : head entry is a misaligned-fetch fault
//                    (only with IF_MISALIGN_EXC_EN defined)
// Optional feature macro: IF_MISALIGN_EXC_EN. When undefined, misaligned
// redirect targets are aligned down to the word.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter int              IMEM_AW    = 16,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [XLEN-1:0]    id_pc,
  output logic [31:0]        id_instr
`ifdef IF_MISALIGN_EXC_EN
  ,
  output logic               id_fault
`endif
);

  import riscv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);
`ifdef IF_MISALIGN_EXC_EN
  localparam int EW = XLEN + 33;
`else
  localparam int EW = XLEN + 32;
`endif
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] fa;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            empty, pop, push, issue, fetch_ok, rsp_push;
  logic [EW-1:0]   push_data, head_data;

`ifdef IF_MISALIGN_EXC_EN
  logic            halt_q, fault_q;
  logic [XLEN-1:0] fault_pc_q;
  logic            mis_redirect;

  assign mis_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  // A misaligned target never reaches memory and stops fetch until the next
  // redirect; any redirect (aligned or not) decides the halt state afresh.
  assign fetch_ok     = redirect_valid ? !mis_redirect : !halt_q;
  assign fa           = redirect_valid ? redirect_pc : pc_q;
`else
  assign fetch_ok     = 1'b1;
  assign fa           = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : pc_q;
`endif

  // A redirect hides the head for one cycle so no entry retires from a
  // buffer that is being flushed.
  assign id_valid  = !rst_n && !empty && !redirect_valid;
  assign pop       = id_valid && id_ready;

  // Reserve a buffer slot for every outstanding read so a response can never
  // arrive to a full FIFO.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue     = !rst_n && fetch_ok && (occupancy < DEPTH_W);

  assign imem_req  = issue;
  assign imem_addr = fa[IMEM_AW+1:2];

  // The response landing during a redirect belongs to the old path.
  assign rsp_push  = inflight_q && !kill_q && !redirect_valid;

`ifdef IF_MISALIGN_EXC_EN
  assign push      = rsp_push || (fault_q && !redirect_valid);
  assign push_data = fault_q ? {fault_pc_q, RV_NOP, 1'b1}
                             : {inflight_pc_q, imem_rdata, 1'b0};
`else
  assign push      = rsp_push;
  assign push_data = {inflight_pc_q, imem_rdata};
`endif

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d   = pc_q;
    kill_d = 1'b0;
    if (issue) begin
      pc_d = fa + {{(XLEN-3){1'b0}}, 3'd4};
    end else if (redirect_valid) begin
      pc_d = fa;
    end
    // When the redirect target itself was issued, its response is kept.
    if (redirect_valid && inflight_q && !issue) kill_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
      halt_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
`endif
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= issue;
      inflight_pc_q <= fa;
      kill_q        <= kill_d;
`ifdef IF_MISALIGN_EXC_EN
      if (redirect_valid) halt_q <= mis_redirect;
      fault_q       <= mis_redirect;
      fault_pc_q    <= redirect_pc;
`endif
    end
  end

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head_data),
    .count_o     (count),
    .empty_o     (empty)
  );

  assign id_pc    = rst_n ? '0 : head_data[EW-1 -: XLEN];
  assign id_instr = rst_n ? '0 : head_data[EW-XLEN-1 -: 32];
`ifdef IF_MISALIGN_EXC_EN
  assign id_fault = rst_n ? 1'b0 : head_data[0];
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Bench for if_fetch_unit (XLEN=32, IMEM_AW=16, FIFO_DEPTH=2). Instruction
// memory holds mem[i] = i. A queue-based model of the fetch stream checks
// the DUT every cycle; directed literals pin the model on the key scenarios.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef IF_MISALIGN_EXC_EN
  logic        id_fault;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .IMEM_AW    (16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
`ifdef IF_MISALIGN_EXC_EN
    ,
    .id_fault       (id_fault)
`endif
  );

  // Synchronous instruction memory, mem[i] = i, one cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {16'h0000, imem_addr};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {16'h0000, pc[17:2]};
  endfunction

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        m_q[$];        // entries buffered for decode
  logic        m_fl;          // a read is outstanding
  logic [31:0] m_fl_pc;
  logic [31:0] m_pc;          // next sequential fetch PC
  logic        m_halt;        // fetch stopped by a misaligned target
  logic        m_fp;          // fault entry to deliver next cycle
  logic [31:0] m_fp_pc;

  // Everything decode accepted, in order.
  logic [31:0] acc_pc[$];
  logic [31:0] acc_instr[$];
  logic        acc_fault[$];

  always @(negedge clk) begin
    logic        exp_valid, pop, issue, ok, mis;
    logic [31:0] fa;
    int          occ;
    ent_t        e;
    if (rst_n) begin
      check("rst_imem_req", {63'd0, imem_req}, 64'd0);
      check("rst_id_valid", {63'd0, id_valid}, 64'd0);
      check("rst_id_pc",    {32'd0, id_pc},    64'd0);
      check("rst_id_instr", {32'd0, id_instr}, 64'd0);
      m_q.delete();
      m_fl = 1'b0; m_fl_pc = '0; m_pc = 32'h0; m_halt = 1'b0; m_fp = 1'b0; m_fp_pc = '0;
    end else begin
      exp_valid = (m_q.size() != 0) && !redirect_valid;
      pop       = exp_valid && id_ready;
`ifdef IF_MISALIGN_EXC_EN
      mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
      ok  = redirect_valid ? !mis : !m_halt;
      fa  = redirect_valid ? redirect_pc : m_pc;
`else
      mis = 1'b0;
      ok  = 1'b1;
      fa  = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : m_pc;
`endif
      occ   = m_q.size() + int'(m_fl) - int'(pop);
      issue = ok && (occ < DEPTH);

      check("imem_req", {63'd0, imem_req}, {63'd0, issue});
      if (issue) check("imem_addr", {48'd0, imem_addr}, {48'd0, fa[17:2]});
      check("id_valid", {63'd0, id_valid}, {63'd0, exp_valid});
      if (exp_valid) begin
        check("id_pc",    {32'd0, id_pc},    {32'd0, m_q[0].pc});
        check("id_instr", {32'd0, id_instr}, {32'd0, m_q[0].instr});
`ifdef IF_MISALIGN_EXC_EN
        check("id_fault", {63'd0, id_fault}, {63'd0, m_q[0].fault});
`endif
      end
      if (pop) begin
        acc_pc.push_back(m_q[0].pc);
        acc_instr.push_back(m_q[0].instr);
        acc_fault.push_back(m_q[0].fault);
      end

      // Advance to the state after this clock edge.
      if (redirect_valid) begin
        m_q.delete();
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_fl) begin
          e.pc = m_fl_pc; e.instr = mem_word(m_fl_pc); e.fault = 1'b0;
          m_q.push_back(e);
        end
        if (m_fp) begin
          e.pc = m_fp_pc; e.instr = 32'h0000_0013; e.fault = 1'b1;
          m_q.push_back(e);
        end
      end
      m_fl    = issue;
      m_fl_pc = fa;
      if (issue) m_pc = fa + 32'd4;
      else if (redirect_valid) m_pc = fa;
      m_fp    = mis;
      m_fp_pc = redirect_pc;
      if (redirect_valid) m_halt = mis;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic check_acc(input string name, input int idx, input logic [31:0] pc, input logic [31:0] instr);
    if (idx < acc_pc.size()) begin
      check({name, "_pc"},    {32'd0, acc_pc[idx]},    {32'd0, pc});
      check({name, "_instr"}, {32'd0, acc_instr[idx]}, {32'd0, instr});
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: entry %0d never accepted (accepted %0d), required pc %0h", name, idx, acc_pc.size(), pc);
    end
  endtask

  initial begin
    int n;
    logic [15:0] pattern;
    logic seen;
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    repeat (3) tick();

    // 1. Reset release, sequential stream.
    rst_n = 1'b0;                                   // cycle 0
    @(negedge clk);
    check("t1_c0_req",  {63'd0, imem_req}, 64'd1);
    check("t1_c0_addr", {48'd0, imem_addr}, 64'd0);
    @(negedge clk);
    check("t1_c1_addr", {48'd0, imem_addr}, 64'd1);
    check("t1_c1_valid", {63'd0, id_valid}, 64'd0);
    @(negedge clk);
    check("t1_c2_valid", {63'd0, id_valid}, 64'd1);
    check("t1_c2_pc",    {32'd0, id_pc},    64'h0);
    @(negedge clk);
    check("t1_c3_pc",    {32'd0, id_pc},    64'h4);
    check("t1_c3_instr", {32'd0, id_instr}, 64'h1);
    @(negedge clk);
    check("t1_c4_pc",    {32'd0, id_pc},    64'h8);
    check("t1_c4_instr", {32'd0, id_instr}, 64'h2);

    // 2. Back-pressure for 5 cycles: head held, fetch stops at 2 entries.
    tick();
    id_ready = 1'b0;                                // cycles 5..9
    @(negedge clk);
    for (int i = 6; i <= 9; i++) begin
      @(negedge clk);
      check("t2_stall_req",   {63'd0, imem_req}, 64'd0);
      check("t2_stall_valid", {63'd0, id_valid}, 64'd1);
      check("t2_stall_pc",    {32'd0, id_pc},    64'hC);
    end
    tick();
    id_ready = 1'b1;
    repeat (4) tick();
    check_acc("t2_acc3", 3, 32'hC,  32'h3);
    check_acc("t2_acc4", 4, 32'h10, 32'h4);
    check_acc("t2_acc5", 5, 32'h14, 32'h5);

    // 3. Redirect with a read in flight and a non-empty buffer.
    n = acc_pc.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("t3_flush_valid", {63'd0, id_valid}, 64'd0);
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();
    check_acc("t3_first",  n,     32'h100, 32'h40);
    check_acc("t3_second", n + 1, 32'h104, 32'h41);

    // 4. Back-to-back redirects: the first target never reaches decode.
    n = acc_pc.size();
    do_redirect(32'h200);
    do_redirect(32'h300);
    repeat (5) tick();
    check_acc("t4_first",  n,     32'h300, 32'hC0);
    check_acc("t4_second", n + 1, 32'h304, 32'hC1);
    seen = 1'b0;
    for (int i = n; i < acc_pc.size(); i++) if (acc_pc[i] == 32'h200) seen = 1'b1;
    check("t4_no_0x200", {63'd0, seen}, 64'd0);

    // 5. PC wrap at the top of the address space.
    n = acc_pc.size();
    do_redirect(32'hFFFF_FFF8);
    repeat (6) tick();
    check_acc("t5_f8",   n,     32'hFFFF_FFF8, 32'hFFFE);
    check_acc("t5_fc",   n + 1, 32'hFFFF_FFFC, 32'hFFFF);
    check_acc("t5_wrap", n + 2, 32'h0,         32'h0);
    check_acc("t5_next", n + 3, 32'h4,         32'h1);

    // 6. Misaligned redirect target.
    n = acc_pc.size();
    do_redirect(32'h102);
    repeat (4) tick();
`ifdef IF_MISALIGN_EXC_EN
    check_acc("t6_fault_entry", n, 32'h102, 32'h13);
    if (n < acc_fault.size()) check("t6_fault_bit", {63'd0, acc_fault[n]}, 64'd1);
    @(negedge clk);
    check("t6_halt_req",   {63'd0, imem_req}, 64'd0);
    check("t6_halt_valid", {63'd0, id_valid}, 64'd0);
    tick();
    n = acc_pc.size();
    do_redirect(32'h400);
    repeat (5) tick();
    check_acc("t6_resume", n, 32'h400, 32'h100);
`else
    check_acc("t6_align",  n,     32'h100, 32'h40);
    check_acc("t6_align2", n + 1, 32'h104, 32'h41);
`endif

    // 7. Irregular decode back-pressure with a redirect mid-stall.
    pattern = 16'b1011_0010_1110_0101;
    for (int i = 0; i < 40; i++) begin
      id_ready = pattern[i % 16];
      if (i == 20) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
